// File: rtl/ts_packet_mux.sv
// ts_packet_mux: round-robin N-channel TS packet multiplexer, one packet per grant, with sync-byte check.
// Define TS_MUX_NULL_PKT_EN to emit null packets instead of idling when no channel is eligible.
module ts_packet_mux #(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int PKT_LEN = 188,
    parameter int GAP_CYC = 0
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic [N_CH-1:0]   GOT_FULL_PACKET,
    input  logic [8*N_CH-1:0] DATA_IN_BUS,
    input  logic [N_CH-1:0]   CH_ENA,
    output logic [N_CH-1:0]   RD_REQ,
    output logic [7:0]        DATA_OUT,
    output logic              D_VALID_OUT,
    output logic              P_SYNC_OUT,
    output logic [CH_W-1:0]   CUR_CH,
    output logic              PKT_DONE,
    output logic              SYNC_ERR
);
    localparam int CNT_W = $clog2(PKT_LEN + 1);
`ifdef TS_MUX_NULL_PKT_EN
    localparam bit NULL_EN = 1'b1;
`else
    localparam bit NULL_EN = 1'b0;
`endif
    typedef enum logic [1:0] {ARB, READ, GAP} state_t;
    state_t state, state_n;
    logic [CH_W-1:0]  ptr, grant, s1_ch;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       gap_cnt, byte_in;
    logic [N_CH-1:0]  elig;
    logic             last_byte, rd_en, s1_vld, s1_first, s1_last;
    assign elig      = GOT_FULL_PACKET & CH_ENA;
    assign last_byte = cnt == CNT_W'(PKT_LEN - 1);
    assign RD_REQ    = rd_en ? N_CH'(1) << CUR_CH : '0;
    // Scan downward so the nearest set bit after ptr is written last and wins.
    always_comb begin
        grant = ptr;
        for (int k = N_CH; k >= 1; k--)
            if (elig[CH_W'((int'(ptr) + k) % N_CH)]) grant = CH_W'((int'(ptr) + k) % N_CH);
    end
    always_comb begin
        state_n = ARB;
        if (state == ARB) state_n = (|elig || NULL_EN) ? READ : ARB;
        else if (state == READ) state_n = last_byte ? (GAP_CYC > 0 ? GAP : ARB) : READ;
        else if (state == GAP) state_n = gap_cnt == 8'(GAP_CYC - 1) ? ARB : GAP;
    end
    always_ff @(posedge SYS_CLK) begin
        if (RST) state <= ARB;
        else state <= state_n;
    end
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            ptr     <= CH_W'(N_CH - 1);
            CUR_CH  <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == ARB && |elig) begin
                ptr    <= grant;
                CUR_CH <= grant;
            end
            cnt     <= (state == READ && !last_byte) ? cnt + 1'b1 : '0;
            gap_cnt <= state == GAP ? gap_cnt + 8'd1 : '0;
        end
    end
`ifdef TS_MUX_NULL_PKT_EN
    logic       null_act, s1_null;
    logic [7:0] s1_nb;
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            null_act <= 1'b0;
            s1_null  <= 1'b0;
            s1_nb    <= '0;
        end else begin
            if (state == ARB) null_act <= ~|elig;
            s1_null <= null_act;
            s1_nb   <= cnt == '0 ? 8'h47 : cnt == CNT_W'(1) ? 8'h1F : cnt == CNT_W'(3) ? 8'h10 : 8'hFF;
        end
    end
    assign rd_en   = state == READ && !null_act;
    assign byte_in = s1_null ? s1_nb : DATA_IN_BUS[{s1_ch, 3'b000} +: 8];
`else
    assign rd_en   = state == READ;
    assign byte_in = DATA_IN_BUS[{s1_ch, 3'b000} +: 8];
`endif
    // Stage 1 tracks the read issued last cycle; stage 2 registers the returned FIFO byte.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            s1_vld      <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_ch       <= '0;
            DATA_OUT    <= '0;
            D_VALID_OUT <= 1'b0;
            P_SYNC_OUT  <= 1'b0;
            PKT_DONE    <= 1'b0;
            SYNC_ERR    <= 1'b0;
        end else begin
            s1_vld      <= state == READ;
            s1_first    <= state == READ && cnt == '0;
            s1_last     <= state == READ && last_byte;
            s1_ch       <= CUR_CH;
            D_VALID_OUT <= s1_vld;
            P_SYNC_OUT  <= s1_first;
            PKT_DONE    <= s1_last;
            SYNC_ERR    <= s1_first && byte_in != 8'h47;
            if (s1_vld) DATA_OUT <= byte_in;
        end
    end
endmodule

// File: tb/tb_ts_packet_mux.sv
// tb_ts_packet_mux: table-driven grant-order vectors, directed corner sequences and random traffic
// checked every cycle against a packet-level reference model of ts_packet_mux.
module tb_ts_packet_mux;
    localparam int N = 4, PL = 188, GAP = 0;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  gfp = '0, ena = '0, rd_req;
    logic [31:0] din = '0;
    logic [7:0]  data_out;
    logic        d_valid, p_sync, pkt_done, sync_err;
    logic [1:0]  cur_ch;
    ts_packet_mux #(.N_CH(N), .CH_W(2), .PKT_LEN(PL), .GAP_CYC(GAP)) dut (
        .SYS_CLK(clk), .RST(rst), .GOT_FULL_PACKET(gfp), .DATA_IN_BUS(din), .CH_ENA(ena),
        .RD_REQ(rd_req), .DATA_OUT(data_out), .D_VALID_OUT(d_valid), .P_SYNC_OUT(p_sync),
        .CUR_CH(cur_ch), .PKT_DONE(pkt_done), .SYNC_ERR(sync_err));
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] content(int ch, int p, int k);
        if (k == 0) return (ch == 2 && p % 2 == 1) ? 8'h00 : 8'h47;
        return 8'(ch * 37 + p * 11 + k);
    endfunction
    function automatic logic [7:0] null_byte(int k);
        return k == 0 ? 8'h47 : k == 1 ? 8'h1F : k == 2 ? 8'hFF : k == 3 ? 8'h10 : 8'hFF;
    endfunction

    // Reference model: remaining-read / remaining-gap counts plus a two-deep output delay.
    int m_ptr, m_cur, m_left, m_gap, m_ch, m_pkt, p_ch, p_pkt, p_k;
    bit m_null, p_v, p_null, e_v, e_s, e_d, e_e;
    logic [7:0] e_data;
    int pk[N], rd_cnt[N];
    task automatic model_step();
        logic [3:0] el;
        int c;
        bit found;
        if (rst) begin
            m_ptr = N - 1; m_cur = 0; m_left = 0; m_gap = 0; m_null = 0; p_v = 0;
            e_data = '0; e_v = 0; e_s = 0; e_d = 0; e_e = 0;
        end else begin
            e_v = p_v; e_s = p_v && p_k == 0; e_d = p_v && p_k == PL - 1;
            if (p_v) e_data = p_null ? null_byte(p_k) : content(p_ch, p_pkt, p_k);
            e_e = e_s && e_data != 8'h47;
            p_v = m_left > 0; p_null = m_null; p_ch = m_ch; p_pkt = m_pkt; p_k = PL - m_left;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_gap = GAP;
            end else if (m_gap > 0) m_gap--;
            else begin
                el = gfp & ena;
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && el[c]) begin
                        found = 1; m_ptr = c; m_cur = c; m_ch = c; m_pkt = pk[c]; pk[c]++;
                        m_left = PL; m_null = 0;
                    end
                end
`ifdef TS_MUX_NULL_PKT_EN
                if (!found) begin m_left = PL; m_null = 1; end
`endif
            end
        end
    endtask

    logic [3:0] prev_rd = '0;
    int grants[$];
    int rd3, serr, rd_any, rd1;
    task automatic step();
        logic [3:0] exp_rd;
        @(negedge clk);
        model_step();
        exp_rd = (m_left > 0 && !m_null) ? 4'(1 << m_ch) : 4'd0;
        chk("cycle", {14'd0, rd_req, data_out, d_valid, p_sync, cur_ch, pkt_done, sync_err},
            {14'd0, exp_rd, e_data, e_v, e_s, 2'(m_cur), e_d, e_e});
        for (int i = 0; i < N; i++)
            if (prev_rd[i]) begin
                din[8*i +: 8] = content(i, rd_cnt[i] / PL, rd_cnt[i] % PL);
                rd_cnt[i]++;
            end
        prev_rd = rd_req;
        if (rd_req[3]) rd3++;
        if (rd_req[1]) rd1++;
        if (rd_req != 0) rd_any++;
        if (p_sync) begin
            grants.push_back(int'(cur_ch));
            if (sync_err) serr++;
        end
    endtask
    // FIFOs drop the partial packet on reset so their next packet starts aligned.
    task automatic realign();
        for (int i = 0; i < N; i++) rd_cnt[i] = ((rd_cnt[i] + PL - 1) / PL) * PL;
    endtask
    task automatic do_reset(logic [3:0] g, logic [3:0] e);
        rst = 1; gfp = g; ena = e;
        step(); step();
        rst = 0;
        realign();
    endtask

    typedef struct { logic [3:0] gfp; logic [3:0] ena; logic [7:0] order; } vec_t;
    vec_t vt[6];
    logic [7:0] got;

    initial begin
        vt[0] = '{4'b0001, 4'hF, 8'h00};
        vt[1] = '{4'b1111, 4'hF, 8'h1B};
        vt[2] = '{4'b1010, 4'b0111, 8'h55};
        vt[3] = '{4'b1100, 4'hF, 8'hBB};
        vt[4] = '{4'b1001, 4'b1110, 8'hFF};
        vt[5] = '{4'b0110, 4'hF, 8'h66};
        gfp = 4'hF; ena = 4'hF;
        step();
        chk("reset_rdreq", 32'(rd_req), 0);
        chk("reset_outs", {19'd0, data_out, d_valid, p_sync, pkt_done, sync_err, cur_ch}, 0);
        for (int v = 0; v < 6; v++) begin
            do_reset(vt[v].gfp, vt[v].ena);
            grants.delete(); rd3 = 0;
            for (int c = 0; c < 4 * (PL + GAP + 1) + 10 && grants.size() < 4; c++) step();
            chk("npkts", grants.size(), 4);
            got = '0;
            foreach (grants[j]) if (j < 4) got[7-2*j -: 2] = 2'(grants[j]);
            chk("order", 32'(got), 32'(vt[v].order));
            if (v == 2) chk("rd3_masked", rd3, 0);
        end
        do_reset(4'b0100, 4'hF);
        grants.delete(); serr = 0;
        for (int c = 0; c < 2 * (PL + GAP + 1) + 10 && grants.size() < 2; c++) step();
        chk("ch2_pkts", grants.size(), 2);
        chk("sync_err_count", serr, 1);
        do_reset(4'hF, 4'hF);
        for (int c = 0; c < 20 && rd_req == 0; c++) step();
        for (int c = 0; c < 100; c++) step();
        chk("byte100_rdreq", 32'(rd_req), 1);
        rst = 1;
        step();
        chk("midrst_rdreq", 32'(rd_req), 0);
        chk("midrst_outs", {19'd0, data_out, d_valid, p_sync, pkt_done, sync_err, cur_ch}, 0);
        gfp = 4'b1100; rst = 0;
        realign();
        for (int c = 0; c < 20 && !p_sync; c++) step();
        chk("post_rst_sync", 32'(p_sync), 1);
        chk("post_rst_grant", 32'(cur_ch), 2);
`ifdef TS_MUX_NULL_PKT_EN
        do_reset(4'b0000, 4'hF);
        grants.delete(); rd_any = 0;
        for (int c = 0; c < 3 * (PL + GAP + 1); c++) step();
        chk("null_rdreq", rd_any, 0);
        chk("null_pkts", 32'(grants.size() >= 2), 1);
        grants.delete(); rd1 = 0;
        for (int c = 0; c < 3 * (PL + GAP + 1) && grants.size() < 1; c++) step();
        for (int c = 0; c < 50; c++) step();
        gfp = 4'b0010;
        grants.delete();
        for (int c = 0; c < 2 * (PL + GAP + 1) + 10 && grants.size() < 1; c++) step();
        chk("null_then_ch1_read", 32'(rd1 > 0), 1);
        chk("null_then_ch1_grant", 32'(cur_ch), 1);
`endif
        do_reset(4'hF, 4'hF);
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 40) == 0) gfp = 4'($urandom);
            if ($urandom_range(0, 60) == 0) ena = 4'($urandom);
            if ($urandom_range(0, 1999) == 0) begin
                rst = 1;
                step();
                rst = 0;
                realign();
            end else step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
